uart_fifo_ctrl: RTL

//   Buffers and sequences byte traffic between the MMIO UART registers and the UART TX/RX cores.

---
 rtl/uart_fifo_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_ctrl.sv
`default_nettype none
// =============================================================================
// Module      : uart_fifo_ctrl
// Description : TX/RX byte FIFOs between the MMIO UART registers and the UART
//               TX/RX cores, with a registered TX output stage.
// Revision    : 1.0  initial release
// =============================================================================
module uart_fifo_ctrl #(
    parameter  int DEPTH  = 8,
    parameter  int DWIDTH = 8,
    localparam int CWIDTH = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_wr_en_in,
    input  logic [DWIDTH-1:0] tx_data_in,
    input  logic              rx_rd_en_in,
    input  logic              err_clr_in,
    output logic [DWIDTH-1:0] rx_data_out,
    output logic              tx_full_out,
    output logic              rx_empty_out,
    output logic [CWIDTH-1:0] tx_count_out,
    output logic [CWIDTH-1:0] rx_count_out,
    output logic              tx_drop_out,
    output logic              rx_stall_out,
    output logic [DWIDTH-1:0] uart_tx_data_out,
    output logic              uart_tx_valid_out,
    input  logic              uart_tx_ready_in,
    input  logic [DWIDTH-1:0] uart_rx_data_in,
    input  logic              uart_rx_valid_in,
    output logic              uart_rx_ready_out
);

    localparam int                AW       = $clog2(DEPTH);
    localparam logic [CWIDTH-1:0] C_FULL   = CWIDTH'(DEPTH);
    localparam logic [CWIDTH-1:0] C_CNT1   = CWIDTH'(1);
    localparam logic [AW-1:0]     C_PTR1   = AW'(1);

    localparam logic [0:0] TX_IDLE = 1'b0;
    localparam logic [0:0] TX_SEND = 1'b1;

    // ------------------------------------------------------------------ TX FIFO
    logic [DWIDTH-1:0] r_tx_mem [DEPTH];
    logic [AW-1:0]     r_tx_wptr;
    logic [AW-1:0]     r_tx_rptr;
    logic [CWIDTH-1:0] r_tx_count;
    logic              w_tx_full;
    logic              w_tx_push;
    logic              w_tx_pop;
    logic              w_tx_done;
    logic              w_tx_avail;

    assign w_tx_full  = (r_tx_count == C_FULL);
    assign w_tx_avail = (r_tx_count != '0);
    assign w_tx_push  = tx_wr_en_in & ~w_tx_full;

    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr] <= tx_data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + C_PTR1;
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + C_PTR1;
            if (w_tx_push && !w_tx_pop)      r_tx_count <= r_tx_count + C_CNT1;
            else if (w_tx_pop && !w_tx_push) r_tx_count <= r_tx_count - C_CNT1;
        end
    end

    // ------------------------------------------------------------------ TX FSM
    logic [0:0]        r_tx_state;
    logic [0:0]        w_tx_next;
    logic [DWIDTH-1:0] r_tx_data;
    logic              r_tx_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_tx_state <= TX_IDLE;
        else        r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE: if (w_tx_avail) w_tx_next = TX_SEND;
            TX_SEND: if (uart_tx_ready_in && !w_tx_avail) w_tx_next = TX_IDLE;
            default: w_tx_next = TX_IDLE;
        endcase
    end

    // A handshake with more data queued reloads the output on the same edge.
    always_comb begin
        w_tx_pop  = 1'b0;
        w_tx_done = 1'b0;
        case (r_tx_state)
            TX_IDLE: w_tx_pop = w_tx_avail;
            TX_SEND: begin
                if (uart_tx_ready_in) begin
                    w_tx_pop  = w_tx_avail;
                    w_tx_done = ~w_tx_avail;
                end
            end
            default: begin
                w_tx_pop  = 1'b0;
                w_tx_done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
        end else if (w_tx_pop) begin
            r_tx_data  <= r_tx_mem[r_tx_rptr];
            r_tx_valid <= 1'b1;
        end else if (w_tx_done) begin
            r_tx_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------ RX FIFO
    logic [DWIDTH-1:0] r_rx_mem [DEPTH];
    logic [AW-1:0]     r_rx_wptr;
    logic [AW-1:0]     r_rx_rptr;
    logic [CWIDTH-1:0] r_rx_count;
    logic              w_rx_full;
    logic              w_rx_empty;
    logic              w_rx_push;
    logic              w_rx_pop;

    assign w_rx_full  = (r_rx_count == C_FULL);
    assign w_rx_empty = (r_rx_count == '0);
    assign w_rx_push  = uart_rx_valid_in & ~w_rx_full;
    assign w_rx_pop   = rx_rd_en_in & ~w_rx_empty;

    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= uart_rx_data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + C_PTR1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + C_PTR1;
            if (w_rx_push && !w_rx_pop)      r_rx_count <= r_rx_count + C_CNT1;
            else if (w_rx_pop && !w_rx_push) r_rx_count <= r_rx_count - C_CNT1;
        end
    end

    // ------------------------------------------------------------ sticky errors
    logic r_tx_drop;
    logic r_rx_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_drop  <= 1'b0;
            r_rx_stall <= 1'b0;
        end else begin
            if (tx_wr_en_in && w_tx_full)     r_tx_drop <= 1'b1;
            else if (err_clr_in)              r_tx_drop <= 1'b0;
            if (uart_rx_valid_in && w_rx_full) r_rx_stall <= 1'b1;
            else if (err_clr_in)               r_rx_stall <= 1'b0;
        end
    end

    // ------------------------------------------------------------------ outputs
    assign rx_data_out       = w_rx_empty ? '0 : r_rx_mem[r_rx_rptr];
    assign tx_full_out       = w_tx_full;
    assign rx_empty_out      = w_rx_empty;
    assign tx_count_out      = r_tx_count;
    assign rx_count_out      = r_rx_count;
    assign tx_drop_out       = r_tx_drop;
    assign rx_stall_out      = r_rx_stall;
    assign uart_tx_data_out  = r_tx_data;
    assign uart_tx_valid_out = r_tx_valid;
    assign uart_rx_ready_out = ~w_rx_full;

endmodule
`default_nettype wire
